lsq: RTL

- Load/store queue sitting directly downstream of the execution stage.
- Accepts load and store requests from the execution stage into an in-order FIFO and issues them one at a time on the core data port.
- Returns aligned, sign/zero-extended load data to the decoder-stage register file write port.
- Reports data-bus errors to the hart vectoring controller.

---
 rtl/lsq.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsq.sv
// Load/store queue: in-order FIFO of execution-stage memory ops, issued one at a time on
// the core data port, with aligned/extended load writeback and data-bus error reporting.
package lsq_pkg;
  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [4:0]  regd;
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0]  hpl;
  } lsq_entry_t;
endpackage

module lsq
  import lsq_pkg::*;
#(
  parameter int unsigned C_XLEN    = 32,
  parameter int unsigned C_DEPTH_X = 2
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  output logic              exs_full_o,
  input  logic              exs_lq_wr_i,
  input  logic              exs_sq_wr_i,
  input  logic [2:0]        exs_funct3_i,
  input  logic [4:0]        exs_regd_addr_i,
  input  logic [C_XLEN-1:0] exs_regs2_data_i,
  input  logic [C_XLEN-1:0] exs_addr_i,
  input  logic [1:0]        exs_hpl_i,
  input  logic              dreqready_i,
  output logic              dreqvalid_o,
  output logic [1:0]        dreqhpl_o,
  output logic [C_XLEN-1:0] dreqaddr_o,
  output logic              dreqwe_o,
  output logic [3:0]        dreqbe_o,
  output logic [C_XLEN-1:0] dreqdata_o,
  output logic              drspready_o,
  input  logic              drspvalid_i,
  input  logic              drsprerr_i,
  input  logic              drspwerr_i,
  input  logic [C_XLEN-1:0] drspdata_i,
  output logic              ids_reg_wr_o,
  output logic [4:0]        ids_reg_addr_o,
  output logic [C_XLEN-1:0] ids_reg_data_o,
  output logic              hvec_lerr_o,
  output logic              hvec_serr_o,
  output logic [C_XLEN-1:0] hvec_err_addr_o,
  output logic              empty_o
);
  localparam int unsigned DEPTH = 2 ** C_DEPTH_X;
  localparam int unsigned PW    = C_DEPTH_X;
  localparam int unsigned CW    = C_DEPTH_X + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  state_t      r_state, w_state_nxt;
  lsq_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
  logic [CW-1:0] r_count, w_count_nxt;
  logic        w_push, w_pop, w_load_req;
  lsq_entry_t  w_push_entry, w_src;
  logic [3:0]  w_be_nxt;
  logic [31:0] w_data_nxt, w_ld_data;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  // entry currently on the bus
  logic        r_cur_st;
  logic [2:0]  r_cur_f3;
  logic [4:0]  r_cur_regd;
  logic [31:0] r_cur_addr;

  logic        r_full, r_empty, r_dreqvalid, r_dreqwe, r_drspready;
  logic [1:0]  r_dreqhpl;
  logic [3:0]  r_dreqbe;
  logic [31:0] r_dreqaddr, r_dreqdata, r_ids_data, r_err_addr;
  logic [4:0]  r_ids_addr;
  logic        r_ids_wr, r_lerr, r_serr;

  // both strobes high records a load
  always_comb begin
    w_push_entry.is_store = exs_sq_wr_i & ~exs_lq_wr_i;
    w_push_entry.funct3   = exs_funct3_i;
    w_push_entry.regd     = exs_regd_addr_i;
    w_push_entry.data     = exs_regs2_data_i;
    w_push_entry.addr     = exs_addr_i;
    w_push_entry.hpl      = exs_hpl_i;
  end

  assign w_push       = clk_en_i & (exs_lq_wr_i | exs_sq_wr_i) & ~r_full;
  assign w_pop        = clk_en_i & (r_state == S_RSP) & drspvalid_i;
  assign w_rd_ptr_inc = r_rd_ptr + PW'(1);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Queue storage and pointers
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clk_en_i) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i)     r_state <= S_IDLE;
    else if (clk_en_i) r_state <= w_state_nxt;
  end

  // Next state; w_src selects the entry that becomes the new request
  always_comb begin
    w_state_nxt = r_state;
    w_load_req  = 1'b0;
    w_src       = r_mem[r_rd_ptr];
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = S_REQ;
          w_load_req  = 1'b1;
        end
      end
      S_REQ: begin
        if (dreqready_i) w_state_nxt = S_RSP;
      end
      S_RSP: begin
        if (drspvalid_i) begin
          if (r_count > CW'(1)) begin
            w_state_nxt = S_REQ;
            w_load_req  = 1'b1;
            w_src       = r_mem[w_rd_ptr_inc];
          end else if (w_push) begin
            w_state_nxt = S_REQ;
            w_load_req  = 1'b1;
            w_src       = w_push_entry;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Store lane steering
  always_comb begin
    w_be_nxt   = 4'b1111;
    w_data_nxt = '0;
    if (w_src.is_store) begin
      w_data_nxt = w_src.data;
      case (w_src.funct3[1:0])
        2'b00: begin
          w_be_nxt   = 4'b0001 << w_src.addr[1:0];
          w_data_nxt = {4{w_src.data[7:0]}};
        end
        2'b01: begin
          w_be_nxt   = 4'b0011 << {w_src.addr[1], 1'b0};
          w_data_nxt = {2{w_src.data[15:0]}};
        end
        default: w_be_nxt = 4'b1111;
      endcase
    end
  end

  // Load lane extraction and extension
  always_comb begin
    w_ld_byte = 8'(drspdata_i >> {r_cur_addr[1:0], 3'b000});
    w_ld_half = 16'(drspdata_i >> {r_cur_addr[1], 4'b0000});
    case (r_cur_f3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = drspdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_dreqvalid <= 1'b0;
      r_drspready <= 1'b0;
      r_dreqhpl   <= '0;
      r_dreqaddr  <= '0;
      r_dreqwe    <= 1'b0;
      r_dreqbe    <= '0;
      r_dreqdata  <= '0;
      r_cur_st    <= 1'b0;
      r_cur_f3    <= '0;
      r_cur_regd  <= '0;
      r_cur_addr  <= '0;
      r_ids_wr    <= 1'b0;
      r_ids_addr  <= '0;
      r_ids_data  <= '0;
      r_lerr      <= 1'b0;
      r_serr      <= 1'b0;
      r_err_addr  <= '0;
    end else if (clk_en_i) begin
      r_full      <= (w_count_nxt == FULL_CNT);
      r_empty     <= (w_count_nxt == '0) && (w_state_nxt == S_IDLE);
      r_dreqvalid <= (w_state_nxt == S_REQ);
      r_drspready <= (w_state_nxt == S_RSP);
      r_ids_wr    <= 1'b0;
      r_lerr      <= 1'b0;
      r_serr      <= 1'b0;
      if (w_load_req) begin
        r_cur_st   <= w_src.is_store;
        r_cur_f3   <= w_src.funct3;
        r_cur_regd <= w_src.regd;
        r_cur_addr <= w_src.addr;
        r_dreqhpl  <= w_src.hpl;
        r_dreqaddr <= {w_src.addr[31:2], 2'b00};
        r_dreqwe   <= w_src.is_store;
        r_dreqbe   <= w_be_nxt;
        r_dreqdata <= w_data_nxt;
      end
      if (w_pop) begin
        if (r_cur_st) begin
          if (drspwerr_i) begin
            r_serr     <= 1'b1;
            r_err_addr <= r_cur_addr;
          end
        end else if (drsprerr_i) begin
          r_lerr     <= 1'b1;
          r_err_addr <= r_cur_addr;
        end else if (r_cur_regd != 5'd0) begin
          r_ids_wr   <= 1'b1;
          r_ids_addr <= r_cur_regd;
          r_ids_data <= w_ld_data;
        end
      end
    end
  end

  assign exs_full_o      = r_full;
  assign empty_o         = r_empty;
  assign dreqvalid_o     = r_dreqvalid;
  assign dreqhpl_o       = r_dreqhpl;
  assign dreqaddr_o      = r_dreqaddr;
  assign dreqwe_o        = r_dreqwe;
  assign dreqbe_o        = r_dreqbe;
  assign dreqdata_o      = r_dreqdata;
  assign drspready_o     = r_drspready;
  assign ids_reg_wr_o    = r_ids_wr;
  assign ids_reg_addr_o  = r_ids_addr;
  assign ids_reg_data_o  = r_ids_data;
  assign hvec_lerr_o     = r_lerr;
  assign hvec_serr_o     = r_serr;
  assign hvec_err_addr_o = r_err_addr;
endmodule
